mem_port_arbiter: RTL and testbench

Parametrised N-port arbiter that lets several clients (VGA controller, core, debug/loader logic) share one synchronous-read block-RAM port. It generalises the fixed two-port RAM split used today: any number of requesters, configurable widths and RAM read latency, one fixed-priority port for display refresh, and round-robin with a starvation guard for everyone else. It sits between the clients and one port of the dual-port VGA RAM.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// N-port arbiter sharing one synchronous-read RAM port: fixed priority for one port,
// round-robin with a starvation guard for the rest. Zero-cycle grant, registered issue.
module mem_port_arbiter #(
  parameter int NUM_PORTS     = 3,
  parameter int ADDR_WIDTH    = 15,
  parameter int DATA_WIDTH    = 16,
  parameter int RD_LATENCY    = 1,
  parameter int PRIORITY_PORT = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  output logic                             mem_we,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [NUM_PORTS-1:0] PRIO_MASK = NUM_PORTS'(1) << PRIORITY_PORT;
  localparam logic [PW-1:0] RR_RESET = PW'((NUM_PORTS > 1 && PRIORITY_PORT == 0) ? 1 : 0);

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] port;
  } tag_t;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

  logic [NUM_PORTS-1:0]  np_req_vec;
  logic                  np_req;
  logic                  rr_found;
  logic [PW-1:0]         rr_idx;
  logic                  trip;
  logic                  win_vld;
  logic                  prio_win;
  logic [PW-1:0]         gnt_idx;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  mem_we_q, mem_we_d;
  tag_t                  tag_q [RD_LATENCY+1];
  tag_t                  tag_d [RD_LATENCY+1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_a[p]  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[p] = wdata[p*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next non-priority index after p, wrapping and skipping the priority port.
  function automatic logic [PW-1:0] next_np(input logic [PW-1:0] p);
    int n;
    n = int'(p) + 1;
    if (n >= NUM_PORTS) n = 0;
    if (n == PRIORITY_PORT && NUM_PORTS > 1) begin
      n = n + 1;
      if (n >= NUM_PORTS) n = 0;
    end
    return PW'(n);
  endfunction

  assign np_req_vec = req & ~PRIO_MASK;
  assign np_req     = |np_req_vec;

  always_comb begin
    int cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!rr_found && np_req_vec[PW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = PW'(cand);
      end
    end
  end

  assign trip = (STARVE_LIMIT != 0) && (starve_q == SW'(STARVE_LIMIT)) && rr_found;

  always_comb begin
    win_vld  = 1'b0;
    prio_win = 1'b0;
    gnt_idx  = '0;
    if (reset_n) begin
      if (req[PRIORITY_PORT] && !trip) begin
        win_vld  = 1'b1;
        prio_win = 1'b1;
        gnt_idx  = PW'(PRIORITY_PORT);
      end else if (rr_found) begin
        win_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  assign gnt = win_vld ? (NUM_PORTS'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_vld && !prio_win) rr_ptr_d = next_np(gnt_idx);

    // Counts only priority wins that actually block a waiting requester.
    starve_d = starve_q;
    if (STARVE_LIMIT == 0 || !np_req || (win_vld && !prio_win)) begin
      starve_d = '0;
    end else if (prio_win) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    mem_we_d   = win_vld && we[gnt_idx];
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (win_vld) begin
      mem_addr_d = addr_a[gnt_idx];
      mem_din_d  = wdata_a[gnt_idx];
    end
  end

  // Tag stage k is valid k+1 cycles after the grant; the last stage lines up with RAM data.
  always_comb begin
    tag_d[0] = '{vld: win_vld && !we[gnt_idx], port: gnt_idx};
    for (int s = 1; s <= RD_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= RR_RESET;
      starve_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      for (int s = 0; s <= RD_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      for (int s = 0; s <= RD_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign rdata    = mem_dout;
  assign rvalid   = tag_q[RD_LATENCY].vld ? (NUM_PORTS'(1) << tag_q[RD_LATENCY].port) : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: three arbiter instances on shared stimulus (guard on, guard off, RD_LATENCY=3),
// each backed by a behavioural synchronous RAM; main instance checked against a scoreboard.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req, we;
  logic [44:0] addr;
  logic [47:0] wdata;

  logic [2:0]  gnt_m, rvalid_m, gnt_n, rvalid_n, gnt_l, rvalid_l;
  logic [15:0] rdata_m, rdata_n, rdata_l, mdin_m, mdin_n, mdin_l, dout_m, dout_n, dout_l;
  logic [14:0] maddr_m, maddr_n, maddr_l;
  logic        mwe_m, mwe_n, mwe_l;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_m), .rvalid(rvalid_m), .rdata(rdata_m), .mem_addr(maddr_m),
    .mem_din(mdin_m), .mem_we(mwe_m), .mem_dout(dout_m));

  mem_port_arbiter #(.STARVE_LIMIT(0)) dut_ng (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_n), .rvalid(rvalid_n), .rdata(rdata_n), .mem_addr(maddr_n),
    .mem_din(mdin_n), .mem_we(mwe_n), .mem_dout(dout_n));

  mem_port_arbiter #(.RD_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_l), .rvalid(rvalid_l), .rdata(rdata_l), .mem_addr(maddr_l),
    .mem_din(mdin_l), .mem_we(mwe_l), .mem_dout(dout_l));

  // Behavioural RAMs
  logic [15:0] ram_m [0:32767];
  logic [15:0] ram_n [0:32767];
  logic [15:0] ram_l [0:32767];
  logic [15:0] pipe_l0, pipe_l1;

  always @(posedge clk) begin
    if (mwe_m) ram_m[maddr_m] <= mdin_m;
    dout_m <= ram_m[maddr_m];
    if (mwe_n) ram_n[maddr_n] <= mdin_n;
    dout_n <= ram_n[maddr_n];
    if (mwe_l) ram_l[maddr_l] <= mdin_l;
    pipe_l0 <= ram_l[maddr_l];
    pipe_l1 <= pipe_l0;
    dout_l  <= pipe_l1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]        req;
    logic [2:0]        we;
    logic [2:0][14:0]  a;
    logic [2:0][15:0]  d;
    logic [2:0]        eg;
  } vec_t;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          due;
  } sb_t;

  function automatic vec_t mkv(input logic [2:0] r, input logic [2:0] w,
                               input logic [14:0] a0, input logic [14:0] a1, input logic [14:0] a2,
                               input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                               input logic [2:0] eg);
    vec_t v;
    v.req = r;
    v.we  = w;
    v.a   = {a2, a1, a0};
    v.d   = {d2, d1, d0};
    v.eg  = eg;
    return v;
  endfunction

  sb_t         sb[$];
  logic [15:0] ref_mem [0:32767];
  vec_t        tbl[$];

  // Expected issue registers from the previous step
  logic        pv_vld = 1'b0;
  logic        pv_we  = 1'b0;
  logic [14:0] pv_a   = '0;
  logic [15:0] pv_d   = '0;
  logic [14:0] last_a = '0;
  logic [15:0] last_d = '0;

  logic [2:0]  g_ng, g_l3, rv_l3;
  logic [15:0] rd_l3;

  task automatic step(input vec_t v, input string nm);
    logic [1:0] idx;
    req   = v.req;
    we    = v.we;
    addr  = v.a;
    wdata = v.d;
    @(negedge clk);
    if (pv_vld) begin
      chk({nm, " mem_addr"}, 48'(maddr_m), 48'(pv_a));
      chk({nm, " mem_we"},   48'(mwe_m),   48'(pv_we));
      chk({nm, " mem_din"},  48'(mdin_m),  48'(pv_d));
    end else begin
      chk({nm, " idle mem_we"},   48'(mwe_m),   48'(0));
      chk({nm, " idle mem_addr"}, 48'(maddr_m), 48'(last_a));
      chk({nm, " idle mem_din"},  48'(mdin_m),  48'(last_d));
    end
    chk({nm, " gnt"}, 48'(gnt_m), 48'(v.eg));
    g_ng  = gnt_n;
    g_l3  = gnt_l;
    rv_l3 = rvalid_l;
    rd_l3 = rdata_l;
    pv_vld = 1'b0;
    if (v.eg != 3'b000) begin
      idx = 2'd0;
      for (int i = 0; i < 3; i++) if (v.eg[i]) idx = 2'(i);
      pv_vld = 1'b1;
      pv_a   = v.a[idx];
      pv_we  = v.we[idx];
      pv_d   = v.d[idx];
      last_a = pv_a;
      last_d = pv_d;
      if (pv_we) ref_mem[pv_a] = pv_d;
      else       sb.push_back('{port: int'(idx), data: ref_mem[pv_a], due: cyc + 2});
    end
    @(posedge clk);
    #1;
  endtask

  // Read-return scoreboard for the main instance
  always @(negedge clk) begin
    sb_t e;
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid missing: port %0d due cycle %0d, now %0d", sb[0].port, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (rvalid_m != 3'b000) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected rvalid: actual %b required none", rvalid_m);
        end else begin
          e = sb.pop_front();
          chk("rvalid port", 48'(rvalid_m), 48'(3'(1) << e.port));
          chk("rdata", 48'(rdata_m), 48'(e.data));
          chk("rvalid cycle", 48'(cyc), 48'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int got1, got2;
    logic [15:0] dat1, dat2;

    reset_n = 1'b0;
    req = 3'b111; we = 3'b000; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset gnt",      48'(gnt_m),    48'(0));
    chk("reset rvalid",   48'(rvalid_m), 48'(0));
    chk("reset mem_we",   48'(mwe_m),    48'(0));
    chk("reset mem_addr", 48'(maddr_m),  48'(0));
    chk("reset mem_din",  48'(mdin_m),   48'(0));
    chk("reset l3 gnt",   48'(gnt_l),    48'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    tbl.push_back(mkv(3'b001, 3'b001, 15'h0010, 15'h0,    15'h0,    16'hBEEF, 16'h0,    16'h0,    3'b001));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mkv(3'b110, 3'b110, 15'h0, 15'h0100, 15'h0200, 16'h0, 16'h1111, 16'h2222, 3'b010));
      tbl.push_back(mkv(3'b110, 3'b110, 15'h0, 15'h0100, 15'h0200, 16'h0, 16'h1111, 16'h2222, 3'b100));
    end
    tbl.push_back(mkv(3'b010, 3'b000, 15'h0,    15'h0010, 15'h0,    16'h0,    16'h0, 16'h0,    3'b010));
    tbl.push_back(mkv(3'b000, 3'b000, 15'h0,    15'h0,    15'h0,    16'h0,    16'h0, 16'h0,    3'b000));
    tbl.push_back(mkv(3'b111, 3'b100, 15'h0100, 15'h0200, 15'h0300, 16'h0,    16'h0, 16'h3333, 3'b001));
    tbl.push_back(mkv(3'b110, 3'b100, 15'h0,    15'h0200, 15'h0300, 16'h0,    16'h0, 16'h3333, 3'b100));
    tbl.push_back(mkv(3'b010, 3'b000, 15'h0,    15'h0200, 15'h0,    16'h0,    16'h0, 16'h0,    3'b010));
    tbl.push_back(mkv(3'b100, 3'b100, 15'h0,    15'h0,    15'h7FFF, 16'h0,    16'h0, 16'h00AA, 3'b100));
    tbl.push_back(mkv(3'b010, 3'b000, 15'h0,    15'h7FFF, 15'h0,    16'h0,    16'h0, 16'h0,    3'b010));
    tbl.push_back(mkv(3'b100, 3'b000, 15'h0,    15'h0,    15'h0300, 16'h0,    16'h0, 16'h0,    3'b100));
    tbl.push_back(mkv(3'b001, 3'b001, 15'h0010, 15'h0,    15'h0,    16'h5A5A, 16'h0, 16'h0,    3'b001));
    tbl.push_back(mkv(3'b001, 3'b000, 15'h0010, 15'h0,    15'h0,    16'h0,    16'h0, 16'h0,    3'b001));
    tbl.push_back(mkv(3'b000, 3'b000, 15'h0,    15'h0,    15'h0,    16'h0,    16'h0, 16'h0,    3'b000));
    tbl.push_back(mkv(3'b000, 3'b000, 15'h0,    15'h0,    15'h0,    16'h0,    16'h0, 16'h0,    3'b000));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // Starvation guard vs. guard disabled
    for (int i = 0; i < 10; i++) begin
      step(mkv(3'b101, 3'b100, 15'h0010, 15'h0, 15'h0400, 16'h0, 16'h0, 16'h4444,
               (i % 5 == 4) ? 3'b100 : 3'b001), $sformatf("starve%0d", i));
      chk($sformatf("noguard%0d gnt", i), 48'(g_ng), 48'(3'b001));
    end
    repeat (3) step(mkv(3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 16'h0, 16'h0, 16'h0, 3'b000), "drain");

    // Reset with two reads in flight on the latency-3 instance
    step(mkv(3'b010, 3'b000, 15'h0, 15'h0010, 15'h0, 16'h0, 16'h0, 16'h0, 3'b010), "inflight0");
    chk("inflight0 l3 gnt", 48'(g_l3), 48'(3'b010));
    step(mkv(3'b010, 3'b000, 15'h0, 15'h0100, 15'h0, 16'h0, 16'h0, 16'h0, 3'b010), "inflight1");
    chk("inflight1 l3 gnt", 48'(g_l3), 48'(3'b010));
    reset_n = 1'b0;
    req = 3'b010;
    sb.delete();
    pv_vld = 1'b0;
    last_a = '0;
    last_d = '0;
    @(negedge clk);
    chk("midreset l3 gnt",      48'(gnt_l),    48'(0));
    chk("midreset l3 rvalid",   48'(rvalid_l), 48'(0));
    chk("midreset l3 mem_we",   48'(mwe_l),    48'(0));
    chk("midreset l3 mem_addr", 48'(maddr_l),  48'(0));
    chk("midreset l3 mem_din",  48'(mdin_l),   48'(0));
    chk("midreset gnt",         48'(gnt_m),    48'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(mkv(3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 16'h0, 16'h0, 16'h0, 3'b000), $sformatf("postrst%0d", i));
      chk($sformatf("postrst%0d l3 rvalid", i), 48'(rv_l3), 48'(0));
    end

    // Pointer is back at port 1; port 2 waits one cycle
    got1 = -1; got2 = -1; dat1 = '0; dat2 = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)
        step(mkv(3'b110, 3'b000, 15'h0, 15'h0010, 15'h0100, 16'h0, 16'h0, 16'h0, 3'b010), "after0");
      else if (k == 1)
        step(mkv(3'b100, 3'b000, 15'h0, 15'h0, 15'h0100, 16'h0, 16'h0, 16'h0, 3'b100), "after1");
      else
        step(mkv(3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 16'h0, 16'h0, 16'h0, 3'b000), $sformatf("after%0d", k));
      if (rv_l3[1]) begin got1 = k; dat1 = rd_l3; end
      if (rv_l3[2]) begin got2 = k; dat2 = rd_l3; end
    end
    chk("l3 port1 rvalid offset", 48'(got1), 48'(4));
    chk("l3 port1 rdata",         48'(dat1), 48'(16'h5A5A));
    chk("l3 port2 rvalid offset", 48'(got2), 48'(5));
    chk("l3 port2 rdata",         48'(dat2), 48'(16'h1111));

    repeat (3) step(mkv(3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 16'h0, 16'h0, 16'h0, 3'b000), "tail");
    chk("scoreboard drained", 48'(sb.size()), 48'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
